// File: rtl/voice_scheduler.sv
// voice_scheduler: maps note-on/note-off events onto a small bank of
// square-wave voices. Each event is accepted in IDLE, the target voice is
// found in SEARCH and the voice registers are updated in COMMIT.
// Optional feature macro: VOICE_SCHEDULER_STEAL_EN -- when defined, a note-on
// arriving with every voice busy overwrites the voice chosen by a round-robin
// steal pointer; when undefined such a note-on is dropped.
module voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int W          = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ev_valid,
    output logic                    ev_ready,
    input  logic                    ev_note_on,
    input  logic [W-1:0]            ev_period,
    input  logic [W-1:0]            ev_duty,
    output logic [NUM_VOICES-1:0]   voice_en,
    output logic [NUM_VOICES*W-1:0] voice_period,
    output logic [NUM_VOICES*W-1:0] voice_duty,
    output logic [NUM_VOICES-1:0]   voice_restart,
    output logic                    ev_dropped
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    // Action decided in SEARCH and carried out in COMMIT.
    localparam logic [2:0] ACT_DROP     = 3'd0;
    localparam logic [2:0] ACT_RETARGET = 3'd1;
    localparam logic [2:0] ACT_ALLOC    = 3'd2;
    localparam logic [2:0] ACT_OFF      = 3'd4;
`ifdef VOICE_SCHEDULER_STEAL_EN
    localparam logic [2:0] ACT_STEAL    = 3'd3;
`endif

    logic [1:0]       state;
    logic             accept;
    logic             ev_note_on_q;
    logic [W-1:0]     ev_period_q;
    logic [W-1:0]     ev_duty_q;
    logic             match_found;
    logic [IDX_W-1:0] match_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [2:0]       act_next;
    logic [IDX_W-1:0] idx_next;
    logic [2:0]       act_q;
    logic [IDX_W-1:0] idx_q;
`ifdef VOICE_SCHEDULER_STEAL_EN
    logic [IDX_W-1:0] steal_ptr;
`endif

    // Ready is forced low while reset is held so nothing is accepted then.
    assign ev_ready = reset && (state == IDLE);
    assign accept   = ev_valid && ev_ready;

    // Three-state sequencer: IDLE -> SEARCH -> COMMIT -> IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= SEARCH;
                SEARCH:  state <= COMMIT;
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the event fields on acceptance; they are only read in SEARCH/COMMIT.
    always_ff @(posedge clk) begin
        if (accept) begin
            ev_note_on_q <= ev_note_on;
            ev_period_q  <= ev_period;
            ev_duty_q    <= ev_duty;
        end
    end

    // Lowest-index enabled voice with the event's period, and lowest-index free voice.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_en[i] && (voice_period[i*W +: W] == ev_period_q)) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
            if (!voice_en[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Pick the action for the in-flight event from the search results.
    always_comb begin
        act_next = ACT_DROP;
        idx_next = '0;
        if (ev_note_on_q) begin
            if (ev_period_q == '0) begin
                act_next = ACT_DROP;
            end else if (match_found) begin
                act_next = ACT_RETARGET;
                idx_next = match_idx;
            end else if (free_found) begin
                act_next = ACT_ALLOC;
                idx_next = free_idx;
            end else begin
`ifdef VOICE_SCHEDULER_STEAL_EN
                act_next = ACT_STEAL;
                idx_next = steal_ptr;
`else
                act_next = ACT_DROP;
`endif
            end
        end else if (match_found) begin
            act_next = ACT_OFF;
            idx_next = match_idx;
        end
    end

    // Register the decision at the end of SEARCH; voices cannot change meanwhile.
    always_ff @(posedge clk) begin
        if (state == SEARCH) begin
            act_q <= act_next;
            idx_q <= idx_next;
        end
    end

    // Voice bank update in COMMIT; restart and dropped are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            voice_en      <= '0;
            voice_period  <= '0;
            voice_duty    <= '0;
            voice_restart <= '0;
            ev_dropped    <= 1'b0;
        end else begin
            voice_restart <= '0;
            ev_dropped    <= 1'b0;
            if (state == COMMIT) begin
                case (act_q)
                    ACT_RETARGET: begin
                        voice_duty[int'(idx_q)*W +: W] <= ev_duty_q;
                    end
`ifdef VOICE_SCHEDULER_STEAL_EN
                    ACT_ALLOC, ACT_STEAL: begin
`else
                    ACT_ALLOC: begin
`endif
                        voice_period[int'(idx_q)*W +: W] <= ev_period_q;
                        voice_duty[int'(idx_q)*W +: W]   <= ev_duty_q;
                        voice_en[idx_q]                  <= 1'b1;
                        voice_restart[idx_q]             <= 1'b1;
                    end
                    ACT_OFF: begin
                        voice_en[idx_q] <= 1'b0;
                    end
                    default: begin
                        ev_dropped <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef VOICE_SCHEDULER_STEAL_EN
    // Round-robin steal pointer advances only when a voice is actually stolen.
    always_ff @(posedge clk) begin
        if (!reset) begin
            steal_ptr <= '0;
        end else if ((state == COMMIT) && (act_q == ACT_STEAL)) begin
            if (steal_ptr == IDX_W'(NUM_VOICES - 1)) begin
                steal_ptr <= '0;
            end else begin
                steal_ptr <= steal_ptr + IDX_W'(1);
            end
        end
    end
`endif

endmodule
